// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle DIV/DIVU controller with restoring shift-subtract datapath
// Stalls the pipeline for 32 iterations (or 1 on divide-by-zero) and pulses ready with {HI, LO}.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        cancel,
    output logic        stall_div,
    output logic        ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DIVZERO, DONE} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [32:0] partRem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        signQ;
    logic        signR;

    logic [31:0] absA;
    logic [31:0] absB;
    logic [33:0] shiftRem;
    logic [33:0] diff;
    logic [32:0] stepRem;
    logic [31:0] stepQuo;
    logic [31:0] fixQuo;
    logic [31:0] fixRem;

    // 0x80000000 negates to itself, which is exactly its magnitude read as unsigned.
    always_comb begin
        absA = (signed_div && opa[31]) ? (32'd0 - opa) : opa;
        absB = (signed_div && opb[31]) ? (32'd0 - opb) : opb;
    end

    // quo starts as the dividend; its MSB shifts into the remainder as quotient bits shift in.
    always_comb begin
        shiftRem = {partRem, quo[31]};
        diff     = shiftRem - {2'b00, divisor};
        if (diff[33]) begin
            stepRem = shiftRem[32:0];
            stepQuo = {quo[30:0], 1'b0};
        end else begin
            stepRem = diff[32:0];
            stepQuo = {quo[30:0], 1'b1};
        end
        fixQuo = signQ ? (32'd0 - stepQuo) : stepQuo;
        fixRem = signR ? (32'd0 - stepRem[31:0]) : stepRem[31:0];
    end

    assign stall_div = ~cancel & (((state == IDLE) & start) | (state == BUSY) | (state == DIVZERO));
    assign ready     = ~cancel & (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= 5'd0;
            partRem <= 33'd0;
            quo     <= 32'd0;
            divisor <= 32'd0;
            signQ   <= 1'b0;
            signR   <= 1'b0;
            result  <= 64'h0;
        end else if (cancel) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo     <= absA;
                        divisor <= absB;
                        partRem <= 33'd0;
                        count   <= 5'd0;
                        signQ   <= signed_div & (opa[31] ^ opb[31]);
                        signR   <= signed_div & opa[31];
                        state   <= (opb == 32'd0) ? DIVZERO : BUSY;
                    end
                end
                BUSY: begin
                    partRem <= stepRem;
                    quo     <= stepQuo;
                    count   <= count + 5'd1;
                    if (count == 5'd31) begin
                        result <= {fixRem, fixQuo};
                        state  <= DONE;
                    end
                end
                DIVZERO: begin
                    result <= 64'h0;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - randomized self-checking bench for div_ctrl
// Expected results come from plain integer division on 64-bit operands.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        cancel;
    logic        stall_div;
    logic        ready;
    logic [63:0] result;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [63:0] lastResult;

    div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_div(signed_div),
        .opa       (opa),
        .opb       (opb),
        .cancel    (cancel),
        .stall_div (stall_div),
        .ready     (ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'h0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Starts in the IDLE cycle following the call and holds start until ready.
    task automatic doDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int stallCnt;
        int readyAt;
        int expLat;
        exp      = refDiv(sgn, a, b);
        expLat   = (b == 32'd0) ? 2 : 33;
        stallCnt = 0;
        readyAt  = -1;
        @(negedge clk);
        start = 1'b1; signed_div = sgn; opa = a; opb = b;
        for (int i = 0; i < 40 && readyAt < 0; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (stall_div && ready) checkVal("stallReadyExcl", {62'd0, stall_div, ready}, 64'd2);
            if (stall_div) stallCnt++;
            if (ready) begin
                readyAt = i;
                start   = 1'b0;
            end
        end
        start = 1'b0;
        checkVal("readyLat", 64'(readyAt), 64'(expLat));
        checkVal("stallCycles", 64'(stallCnt), 64'(expLat));
        checkVal($sformatf("result %s %h/%h", sgn ? "DIV" : "DIVU", a, b), result, exp);
        lastResult = exp;
    endtask

    initial begin
        int pulses;
        logic [31:0] a, b;
        bit sgn;

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkVal("rstReady", {63'd0, ready}, 64'd0);
        checkVal("rstStall", {63'd0, stall_div}, 64'd0);
        checkVal("rstResult", result, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        doDiv(1'b0, 32'd100, 32'd7);
        doDiv(1'b1, 32'hFFFFFFF9, 32'd2);
        doDiv(1'b1, 32'd7, 32'hFFFFFFFE);
        doDiv(1'b0, 32'd5, 32'd0);
        doDiv(1'b1, 32'h80000000, 32'hFFFFFFFF);
        doDiv(1'b0, 32'hFFFFFFFF, 32'd1);

        // Cancel at BUSY counter 10 (11th cycle after acceptance).
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
        repeat (11) @(negedge clk);
        cancel = 1'b1;
        #1;
        checkVal("cancelStall", {63'd0, stall_div}, 64'd0);
        checkVal("cancelReady", {63'd0, ready}, 64'd0);
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (ready) pulses++;
        end
        checkVal("cancelNoReady", 64'(pulses), 64'd0);
        checkVal("cancelResultHeld", result, lastResult);
        doDiv(1'b0, 32'd9, 32'd3);

        // Asynchronous reset between edges while BUSY.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b1; opa = 32'd12345; opb = 32'd17;
        repeat (15) @(negedge clk);
        start = 1'b0;
        #3 rst = 1'b1;
        #1;
        checkVal("asyncRstReady", {63'd0, ready}, 64'd0);
        checkVal("asyncRstStall", {63'd0, stall_div}, 64'd0);
        checkVal("asyncRstResult", result, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (ready) pulses++;
        end
        checkVal("rstNoReady", 64'(pulses), 64'd0);
        doDiv(1'b0, 32'd77, 32'd5);
        doDiv(1'b1, 32'hFFFFFF00, 32'd9);

        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 20);
                3: b = 32'd0 - $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            doDiv(sgn, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-high.
REQ-003: start  input  1  DIV/DIVU instruction present in execute stage; held high by pipeline while stall_div=1.
REQ-004: signed_div  input  1  1=DIV (two's complement), 0=DIVU; sampled with start in IDLE.
REQ-005: opa  input  32  dividend; sampled with start in IDLE.
REQ-006: opb  input  32  divisor; sampled with start in IDLE.
REQ-007: cancel  input  1  execute-stage flush/exception; aborts any operation.
REQ-008: stall_div  output  1  to hazard unit as stall_divE; freezes F/D/E while division in progress.
REQ-009: ready  output  1  one-cycle pulse: result valid.
REQ-010: result  output  64  {remainder (HI), quotient (LO)}.

Function
REQ-011: FSM states IDLE, BUSY, DIVZERO, DONE; encoding implementation-defined.
REQ-012: IDLE: start=1 & cancel=0 -> BUSY if opb!=0, DIVZERO if opb==0; latch |opa|, |opb|, sign_q=opa[31]^opb[31], sign_r=opa[31] (signs forced 0 when signed_div=0); clear iteration counter to 0.
REQ-013: BUSY: one restoring shift-subtract step per cycle on a 33-bit partial remainder; counter increments 0..31; step with counter==31 completes -> DONE.
REQ-014: DIVZERO: one cycle, -> DONE; result = 64'h0.
REQ-015: DONE: ready=1, result valid, stall_div=0; unconditionally -> IDLE next cycle; start in DONE ignored.
REQ-016: stall_div = (IDLE & start & ~cancel) | BUSY | DIVZERO, combinational.
REQ-017: Latency: start accepted cycle N; BUSY cycles N+1..N+32; ready at N+33; stall_div high N..N+32 (33 cycles); divide-by-zero: ready at N+2.
REQ-018: Signed fix-up at completion: quotient negated if sign_q, remainder negated if sign_r; remainder sign always equals dividend sign, |remainder| < |divisor|.
REQ-019: 0x80000000 / 0xFFFFFFFF signed: |opa|=0x80000000 as unsigned; result quotient 0x80000000, remainder 0; no trap.
REQ-020: result register holds last value until next DONE; not cleared by IDLE or cancel.
REQ-021: cancel=1 in any state: stall_div=0 same cycle, ready=0, next state IDLE; cancel has priority over start and completion.
REQ-022: Back-to-back divides: new start accepted in IDLE immediately after DONE (minimum 1-cycle gap).
REQ-023: stall_div and ready never both 1 in the same cycle.

Reset
REQ-024: rst=1 asynchronously forces state IDLE, counter 0, partial remainder/quotient 0, result 64'h0, ready 0; stall_div then follows REQ-016.
REQ-025: rst mid-BUSY aborts operation; no ready pulse; first start after rst release starts fresh 33-cycle sequence.

Verification
REQ-026: DIVU 100/7, start held -> stall_div high 33 cycles, ready at N+33, result = {32'd2, 32'd14}.
REQ-027: DIV 0xFFFFFFF9(-7)/2 -> result = {32'hFFFFFFFF, 32'hFFFFFFFD}; DIV 7/0xFFFFFFFE(-2) -> {32'd1, 32'hFFFFFFFD}.
REQ-028: DIVU 5/0 -> stall_div high cycles N..N+1, ready at N+2, result = 64'h0.
REQ-029: DIV 0x80000000/0xFFFFFFFF -> result = {32'h0, 32'h80000000}; DIVU 0xFFFFFFFF/1 -> {32'h0, 32'hFFFFFFFF}.
REQ-030: cancel pulsed at BUSY counter 10 -> stall_div 0 that cycle, no ready pulse, result unchanged; subsequent DIVU 9/3 -> {32'd0, 32'd3} with full 33-cycle stall.
REQ-031: rst asserted mid-BUSY asynchronously (between edges) -> outputs reset immediately, ready never pulses; two back-to-back divides after release each produce exactly one ready pulse.
